// File: rtl/retire_trace_buffer.sv
// Retirement-trace recorder: classifies retired instructions, captures them into a
// circular buffer, freezes a programmable number of entries after a PC trigger, then drains oldest-first.
module retire_trace_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     retire_valid,
  input  logic [XLEN-1:0]          retire_pc,
  input  logic [31:0]              retire_instr,
  input  logic                     retire_reg_write,
  input  logic [4:0]               retire_rd,
  input  logic [XLEN-1:0]          retire_wb_data,
  input  logic                     retire_branch,
  input  logic                     retire_branch_taken,
  input  logic                     retire_mem_write,
  input  logic [XLEN-1:0]          retire_store_data,
  input  logic [2:0]               filter_mask,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic                     arm,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_pc,
  output logic [31:0]              rd_instr,
  output logic [1:0]               rd_kind,
  output logic [4:0]               rd_rd,
  output logic [XLEN-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     triggered,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARMED  = 2'b01,
    S_POST   = 2'b10,
    S_FROZEN = 2'b11
  } state_t;

  state_t          cur_st, nxt_st;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW-1:0]   post_cnt;
  logic [1:0]      kind;
  logic [4:0]      ent_rd;
  logic [XLEN-1:0] ent_data;
  logic            cls_en, capture, trig_hit, clear, pop, full;

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [31:0]     mem_instr[DEPTH];
  logic [1:0]      mem_kind [DEPTH];
  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];

  // Classification priority: regwrite (rd != x0) > branch > store.
  always_comb begin
    kind     = 2'b00;
    ent_rd   = '0;
    ent_data = '0;
    if (retire_reg_write && retire_rd != 5'd0) begin
      kind     = 2'b01;
      ent_rd   = retire_rd;
      ent_data = retire_wb_data;
    end else if (retire_branch) begin
      kind     = 2'b10;
      ent_data = {{(XLEN-1){1'b0}}, retire_branch_taken};
    end else if (retire_mem_write) begin
      kind     = 2'b11;
      ent_data = retire_store_data;
    end
  end

  always_comb begin
    cls_en = 1'b0;
    unique case (kind)
      2'b01:   cls_en = filter_mask[0];
      2'b10:   cls_en = filter_mask[1];
      2'b11:   cls_en = filter_mask[2];
      default: cls_en = 1'b0;
    endcase
  end

  assign capture  = retire_valid && (retire_instr != '0) && cls_en &&
                    (cur_st == S_ARMED || cur_st == S_POST);
  assign trig_hit = capture && (cur_st == S_ARMED) && trig_en && (retire_pc == trig_pc);
  assign clear    = arm && (cur_st == S_IDLE || cur_st == S_FROZEN);
  assign pop      = (cur_st == S_FROZEN) && rd_en && (count != '0) && !arm;
  assign full     = (count == CW'(DEPTH));
  assign state    = cur_st;

  always_comb begin
    nxt_st = cur_st;
    unique case (cur_st)
      S_IDLE:   if (arm) nxt_st = S_ARMED;
      S_ARMED:  if (trig_hit) nxt_st = (POST_TRIG == 0) ? S_FROZEN : S_POST;
      S_POST:   if (capture && post_cnt == AW'(1)) nxt_st = S_FROZEN;
      S_FROZEN: if (arm) nxt_st = S_ARMED;
      default:  nxt_st = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st    <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_pc     <= '0;
      rd_instr  <= '0;
      rd_kind   <= '0;
      rd_rd     <= '0;
      rd_data   <= '0;
    end else begin
      cur_st   <= nxt_st;
      rd_valid <= 1'b0;
      if (clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        triggered <= 1'b0;
        overflow  <= 1'b0;
      end else if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        // A full buffer drops its oldest entry so the read side tracks the write side.
        if (full) begin
          rd_ptr   <= rd_ptr + AW'(1);
          overflow <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
        if (trig_hit) begin
          triggered <= 1'b1;
          post_cnt  <= AW'(POST_TRIG);
        end else if (cur_st == S_POST) begin
          post_cnt <= post_cnt - AW'(1);
        end
      end else if (pop) begin
        rd_valid <= 1'b1;
        rd_pc    <= mem_pc[rd_ptr];
        rd_instr <= mem_instr[rd_ptr];
        rd_kind  <= mem_kind[rd_ptr];
        rd_rd    <= mem_rd[rd_ptr];
        rd_data  <= mem_data[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
        count    <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_pc[wr_ptr]    <= retire_pc;
      mem_instr[wr_ptr] <= retire_instr;
      mem_kind[wr_ptr]  <= kind;
      mem_rd[wr_ptr]    <= ent_rd;
      mem_data[wr_ptr]  <= ent_data;
    end
  end

endmodule
